// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and data access.
// Build option ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests; otherwise data has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_D
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   grant_if;
    logic   grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the data port won the most recent grant.
    logic last_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_d <= 1'b0;
        end else if (grant_d) begin
            last_d <= 1'b1;
        end else if (grant_if) begin
            last_d <= 1'b0;
        end
    end

    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state == IDLE) begin
            if (if_req && d_req) begin
                grant_d  = !last_d;
                grant_if = last_d;
            end else begin
                grant_d  = d_req;
                grant_if = if_req;
            end
        end
    end
`else
    always_comb begin
        grant_d  = (state == IDLE) && d_req;
        grant_if = (state == IDLE) && if_req && !d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = BUSY_D;
                end else if (grant_if) begin
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state != IDLE);
    end

    // Access attributes are captured only at grant, so requester changes while busy are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_valid <= (state == BUSY_IF) && mem_ready;
            d_valid  <= (state == BUSY_D) && mem_ready;
            if ((state == BUSY_IF) && mem_ready) begin
                if_rdata <= mem_rdata;
            end
            if ((state == BUSY_D) && mem_ready && !mem_we) begin
                d_rdata <= mem_rdata;
            end
            if (grant_d) begin
                mem_addr  <= d_addr;
                mem_we    <= d_we;
                mem_wdata <= d_wdata;
            end else if (grant_if) begin
                mem_addr <= if_addr;
                mem_we   <= 1'b0;
            end
        end
    end

endmodule
